video_timing_gen: RTL

//  Raster timing generator at the head of the video pipeline. Produces pixel coordinates and a linear

---
 rtl/video_timing_gen_pkg.sv | 31 +++
 rtl/video_timing_gen_delay_line.sv | 28 ++
 rtl/video_timing_gen.sv | 139 +++++++++++++
 3 files changed

// File: rtl/video_timing_gen_pkg.sv
// Shared raster-timing constants, FSM encodings and the delayed control payload.
// Defaults describe 640x480@60 (800x525 total).
package video_timing_gen_pkg;

   localparam int DEF_H_ACT  = 640;
   localparam int DEF_H_FP   = 16;
   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BP   = 48;
   localparam int DEF_V_ACT  = 480;
   localparam int DEF_V_FP   = 10;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BP   = 33;
   localparam int DEF_CNTW   = 10;
   localparam int DEF_MAW    = 19;
   localparam int DEF_DLY    = 3;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // One stage of the sync/active alignment pipe, at output polarity.
   typedef struct packed {
      logic act;
      logic hs;
      logic vs;
   } vid_ctl_t;

   function automatic int span_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

endpackage

// File: rtl/video_timing_gen_delay_line.sv
// Clock-enable gated shift register; every stage resets to RST_VAL.
// Used to align sync/active with the downstream pixel path latency.
module video_delay_line #(
   parameter int             W       = 3,
   parameter int             DLY     = 3,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clk_en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [DLY-1:0][W-1:0] pipe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe <= {DLY{RST_VAL}};
      end else if (clk_en) begin
         pipe[0] <= d;
         for (int i = 1; i < DLY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign q = pipe[DLY-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel coordinates, linear VRAM read address and
// sync/active outputs delayed to line up with the index-RAM/CLUT pixel path.
module video_timing_gen
   import video_timing_gen_pkg::*;
#(
   parameter int H_ACT    = DEF_H_ACT,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACT    = DEF_V_ACT,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CNTW     = DEF_CNTW,
   parameter int MAW      = DEF_MAW,
   parameter int PIPE_DLY = DEF_DLY
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clk_en,
   input  logic            en,
   output logic [CNTW-1:0] pix_x,
   output logic [CNTW-1:0] pix_y,
   output logic [MAW-1:0]  pix_adr,
   output logic            adr_valid,
   output logic            line_start,
   output logic            frame_start,
   output logic            vid_active,
   output logic            vid_hsync,
   output logic            vid_vsync
);

   localparam int H_TOT = span_total(H_ACT, H_FP, H_SYNC, H_BP);
   localparam int V_TOT = span_total(V_ACT, V_FP, V_SYNC, V_BP);

   if (H_TOT > (1 << CNTW)) begin : g_h_chk
      $fatal(1, "video_timing_gen: H_TOT does not fit in CNTW bits");
   end
   if (V_TOT > (1 << CNTW)) begin : g_v_chk
      $fatal(1, "video_timing_gen: V_TOT does not fit in CNTW bits");
   end
   if (PIPE_DLY < 1) begin : g_dly_chk
      $fatal(1, "video_timing_gen: PIPE_DLY must be at least 1");
   end

   localparam logic [CNTW-1:0] H_LAST = CNTW'(H_TOT - 1);
   localparam logic [CNTW-1:0] V_LAST = CNTW'(V_TOT - 1);
   // One spare bit so a sync window ending exactly at 2**CNTW still compares correctly.
   localparam logic [CNTW:0]   H_A  = (CNTW+1)'(H_ACT);
   localparam logic [CNTW:0]   H_S0 = (CNTW+1)'(H_ACT + H_FP);
   localparam logic [CNTW:0]   H_S1 = (CNTW+1)'(H_ACT + H_FP + H_SYNC);
   localparam logic [CNTW:0]   V_A  = (CNTW+1)'(V_ACT);
   localparam logic [CNTW:0]   V_S0 = (CNTW+1)'(V_ACT + V_FP);
   localparam logic [CNTW:0]   V_S1 = (CNTW+1)'(V_ACT + V_FP + V_SYNC);
   localparam logic [MAW-1:0]  ADR_LAST = MAW'(H_ACT * V_ACT - 1);

   localparam vid_ctl_t CTL_IDLE = '{act: 1'b0, hs: ~HS_POL, vs: ~VS_POL};

   logic [0:0]      state;
   logic [CNTW-1:0] h, v;
   logic [CNTW:0]   hx, vx;
   logic            run, h_last, v_last;
   logic            act, hs_on, vs_on;
   vid_ctl_t        ctl_in, ctl_out;

   assign run    = (state == ST_RUN);
   assign hx     = {1'b0, h};
   assign vx     = {1'b0, v};
   assign h_last = (h == H_LAST);
   assign v_last = (v == V_LAST);

   // Every decode is gated by RUN, so IDLE feeds inactive levels into the pipe.
   assign act   = run && (hx < H_A) && (vx < V_A);
   assign hs_on = run && (hx >= H_S0) && (hx < H_S1);
   assign vs_on = run && (vx >= V_S0) && (vx < V_S1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         h       <= '0;
         v       <= '0;
         pix_adr <= '0;
      end else if (clk_en) begin
         case (state)
            ST_IDLE: begin
               h       <= '0;
               v       <= '0;
               pix_adr <= '0;
               if (en) state <= ST_RUN;
            end
            ST_RUN: begin
               if (h_last) begin
                  h <= '0;
                  if (v_last) begin
                     v <= '0;
                     // en is only looked at here, so a started frame always completes.
                     if (!en) state <= ST_IDLE;
                  end else begin
                     v <= v + 1'b1;
                  end
               end else begin
                  h <= h + 1'b1;
               end
               if (act) pix_adr <= (pix_adr == ADR_LAST) ? '0 : pix_adr + 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign pix_x       = h;
   assign pix_y       = v;
   assign adr_valid   = act;
   assign line_start  = run && (h == '0);
   assign frame_start = run && (h == '0) && (v == '0);

   assign ctl_in.act = act;
   assign ctl_in.hs  = hs_on ? HS_POL : ~HS_POL;
   assign ctl_in.vs  = vs_on ? VS_POL : ~VS_POL;

   video_delay_line #(
      .W       ($bits(vid_ctl_t)),
      .DLY     (PIPE_DLY),
      .RST_VAL (CTL_IDLE)
   ) u_ctl_dly (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .d      (ctl_in),
      .q      (ctl_out)
   );

   assign vid_active = ctl_out.act;
   assign vid_hsync  = ctl_out.hs;
   assign vid_vsync  = ctl_out.vs;

endmodule
